print_ps_bridge: RTL and testbench

- Sits directly downstream of the SOC print port.
- Captures the 32-bit words that the SOC emits on its print_ps_en/print_ps_data strobe into a local buffer. When the SOC marks the end of a message with print_ps_finish, the block raises an interrupt to the PS.
- The PS reads the buffered words by index and acknowledges with a done pulse. The bridge then returns a one-cycle finish pulse to the SOC's print_ps_finish_i input.

---
 rtl/print_ps_bridge.sv | 126 ++++++++++++
 tb/tb_print_ps_bridge.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/print_ps_bridge.sv
// print_ps_bridge: buffers SOC print words, raises a PS interrupt per message,
// and returns a one-cycle finish pulse to the SOC once the PS acknowledges.
// Ports:
//   clk_sys_i, rst_sys_i            clock, sync active-high reset
//   soc_print_en_i/data_i/finish_i  SOC print word strobe, word, end of message
//   soc_print_finish_o              one-cycle completion pulse back to SOC
//   ps_irq_o                        message ready (level)
//   ps_count_o, ps_overflow_o       message word count, words-lost flag
//   ps_rd_addr_i, ps_rd_data_o      PS read index, registered read data
//   ps_done_i                       PS acknowledge pulse
module print_ps_bridge #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_i,
  input  logic              soc_print_en_i,
  input  logic [31:0]       soc_print_data_i,
  input  logic              soc_print_finish_i,
  output logic              soc_print_finish_o,
  output logic              ps_irq_o,
  output logic [ADDR_W:0]   ps_count_o,
  output logic              ps_overflow_o,
  input  logic [ADDR_W-1:0] ps_rd_addr_i,
  output logic [31:0]       ps_rd_data_o,
  input  logic              ps_done_i
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_PS = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            ovf_nx_q, ovf_nx_d;
  logic [31:0]     rd_q;
  logic [31:0]     mem [DEPTH];

  logic            full;
  logic            accept;
  logic            we;
  logic [ADDR_W:0] count_w;

  assign full    = (count_q == DEPTH_C);
  // Words are taken in IDLE and DONE; WAIT_PS keeps the buffer frozen.
  assign accept  = soc_print_en_i && (state_q != WAIT_PS);
  assign we      = accept && !full;
  assign count_w = count_q + {{ADDR_W{1'b0}}, we};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    ovf_nx_d = ovf_nx_q;
    unique case (state_q)
      IDLE: begin
        count_d = count_w;
        if (accept && full) ovf_d = 1'b1;
        if (soc_print_finish_i) begin
          if (count_w != '0) begin
            state_d = WAIT_PS;
          end else begin
            // Empty message: skip the PS entirely.
            state_d  = DONE;
            count_d  = '0;
            ovf_d    = ovf_nx_q;
            ovf_nx_d = 1'b0;
          end
        end
      end
      WAIT_PS: begin
        if (soc_print_en_i) ovf_nx_d = 1'b1;
        if (ps_done_i) begin
          state_d  = DONE;
          count_d  = '0;
          // A word dropped in the same cycle still marks the next message.
          ovf_d    = ovf_nx_q | soc_print_en_i;
          ovf_nx_d = 1'b0;
        end
      end
      DONE: begin
        // Count is 0 here, so en starts the next message at index 0.
        state_d = IDLE;
        count_d = count_w;
        if (accept && full) ovf_d = 1'b1;
        // A finish seen only in DONE is lost; flag the next message.
        if (soc_print_finish_i) ovf_nx_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ovf_nx_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ovf_nx_q <= ovf_nx_d;
      rd_q     <= mem[ps_rd_addr_i];
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (we) mem[count_q[ADDR_W-1:0]] <= soc_print_data_i;
  end

  assign soc_print_finish_o = (state_q == DONE);
  assign ps_irq_o           = (state_q == WAIT_PS);
  assign ps_count_o         = count_q;
  assign ps_overflow_o      = ovf_q;
  assign ps_rd_data_o       = rd_q;

endmodule

// File: tb/tb_print_ps_bridge.sv
// tb_print_ps_bridge: table-driven bench for print_ps_bridge (ADDR_W=2),
// read data checked through an expected-value queue.
module tb_print_ps_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] data = '0;
  logic        fin = 1'b0;
  logic        done = 1'b0;
  logic [1:0]  addr = '0;
  logic        sfin_o;
  logic        irq_o;
  logic [2:0]  cnt_o;
  logic        ovf_o;
  logic [31:0] rd_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  print_ps_bridge #(.ADDR_W(2)) dut (
    .clk_sys_i          (clk),
    .rst_sys_i          (rst),
    .soc_print_en_i     (en),
    .soc_print_data_i   (data),
    .soc_print_finish_i (fin),
    .soc_print_finish_o (sfin_o),
    .ps_irq_o           (irq_o),
    .ps_count_o         (cnt_o),
    .ps_overflow_o      (ovf_o),
    .ps_rd_addr_i       (addr),
    .ps_rd_data_o       (rd_o),
    .ps_done_i          (done)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] data;
    logic        fin;
    logic        done;
    logic [1:0]  addr;
    logic        rd;
    logic [31:0] rd_exp;
    logic        irq;
    logic [2:0]  cnt;
    logic        ovf;
    logic        sfin;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];

  function automatic vec_t mk(
    input logic r, input logic e, input logic [31:0] d,
    input logic f, input logic dn, input logic [1:0] a,
    input logic rd, input logic [31:0] rx,
    input logic i, input logic [2:0] c,
    input logic o, input logic s);
    vec_t v;
    v.rst = r; v.en = e; v.data = d; v.fin = f; v.done = dn;
    v.addr = a; v.rd = rd; v.rd_exp = rx;
    v.irq = i; v.cnt = c; v.ovf = o; v.sfin = s;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Entered and left at a negedge: drive, let one posedge pass, compare.
  task automatic step(input string nm, input vec_t v);
    logic [31:0] e;
    rst = v.rst; en = v.en; data = v.data;
    fin = v.fin; done = v.done; addr = v.addr;
    if (v.rd) sb.push_back(v.rd_exp);
    @(negedge clk);
    chk({nm, " irq"}, 32'(irq_o), 32'(v.irq));
    chk({nm, " count"}, 32'(cnt_o), 32'(v.cnt));
    chk({nm, " ovf"}, 32'(ovf_o), 32'(v.ovf));
    chk({nm, " fin_o"}, 32'(sfin_o), 32'(v.sfin));
    if (v.rd) begin
      e = sb.pop_front();
      chk({nm, " rd_data"}, rd_o, e);
    end
  endtask

  initial begin
    // 1: three words then finish, read back, ack
    tbl.push_back(mk(0,1,'h11,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,1,'h22,0,0,0,0,0, 0,2,0,0));
    tbl.push_back(mk(0,1,'h33,0,0,0,0,0, 0,3,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,    1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h11, 1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1,'h22, 1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,2,1,'h33, 1,3,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0,    0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,    0,0,0,0));
    // 2: six words into depth 4 -> saturate and overflow
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0,1,32'hA0 + 32'(i),0,0,0,0,0,
                       0, (i < 4) ? 3'(i + 1) : 3'd4, (i >= 4), 0));
    tbl.push_back(mk(0,0,0,1,0,0,0,0, 1,4,1,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0,0,2'(i),1,32'hA0 + 32'(i), 1,4,1,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0));
    // 3: empty message -> straight to finish pulse, no irq
    tbl.push_back(mk(0,0,0,1,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0));
    // 4: words dropped in WAIT_PS flag the next message
    tbl.push_back(mk(0,1,'h77,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,    1,1,0,0));
    tbl.push_back(mk(0,1,'h01,0,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,1,'h02,0,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0,    0,0,1,1));
    tbl.push_back(mk(0,1,'h88,0,0,0,0,0, 0,1,1,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,    1,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h88, 1,1,1,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0,    0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,    0,0,0,0));
    // 5: en + finish same cycle, then en/finish during DONE
    tbl.push_back(mk(0,1,'h55,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h55, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0,    0,0,0,1));
    tbl.push_back(mk(0,1,'h66,1,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,    1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h66, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0,    0,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,    0,0,1,0));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst irq", 32'(irq_o), 32'd0);
    chk("rst count", 32'(cnt_o), 32'd0);
    chk("rst ovf", 32'(ovf_o), 32'd0);
    chk("rst fin_o", 32'(sfin_o), 32'd0);
    chk("rst rd_data", rd_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("row%0d", i), tbl[i]);

    // Reset while the PS holds a 3-word message
    step("r0", mk(0,1,'hC1,0,0,0,0,0, 0,1,1,0));
    step("r1", mk(0,1,'hC2,0,0,0,0,0, 0,2,1,0));
    step("r2", mk(0,1,'hC3,0,0,0,0,0, 0,3,1,0));
    step("r3", mk(0,0,0,1,0,0,0,0,    1,3,1,0));
    step("r4", mk(1,0,0,0,0,0,0,0,    0,0,0,0));
    step("r5", mk(0,0,0,0,0,0,0,0,    0,0,0,0));
    step("r6", mk(0,0,0,0,0,0,0,0,    0,0,0,0));
    step("r7", mk(0,1,'hD0,1,0,0,0,0, 1,1,0,0));
    step("r8", mk(0,0,0,0,0,0,1,'hD0, 1,1,0,0));
    step("r9", mk(0,0,0,0,1,0,0,0,    0,0,0,1));
    step("r10", mk(0,0,0,0,0,0,0,0,   0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
